// File: rtl/inject_fifo.sv
// inject_fifo: injection-side buffer between a node's packet generator and
// the router's local inject port. Packets are queued in a DEPTH-entry FIFO.
// The head is presented with a valid/ack handshake, and the block keeps a
// saturating count of packets it had to discard.
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   X, Y             this node's coordinates (static after reset)
//   pkt_in/pkt_push  generator write side; dest X/Y in the top 2*MM bits
//   full             FIFO holds DEPTH entries
//   inject/inj       head packet / head valid (FIFO not empty)
//   inj_ack          router took the head this cycle
//   count            occupancy 0..DEPTH
//   drop_cnt         saturating count of discarded pushes
//
// Build option: define INJ_SELF_DROP_EN to discard self-addressed pushes.
// A discarded self-addressed push counts in drop_cnt.
module inject_fifo #(
  parameter int LL    = 16,
  parameter int MM    = 2,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [MM-1:0] X,
  input  logic [MM-1:0] Y,
  input  logic [LL-1:0] pkt_in,
  input  logic          pkt_push,
  output logic          full,
  output logic [LL-1:0] inject,
  output logic          inj,
  input  logic          inj_ack,
  output logic [AW:0]   count,
  output logic [7:0]    drop_cnt
);

  logic [DEPTH-1:0][LL-1:0] mem;
  logic [AW-1:0]            rp, wp;
  logic                     self_hit, wr, drop, pop;

  // Destination field of the incoming packet matches this node.
  logic self_match;
  assign self_match = (pkt_in[LL-1 -: MM] == X) && (pkt_in[LL-MM-1 -: MM] == Y);

`ifdef INJ_SELF_DROP_EN
  assign self_hit = self_match;
`else
  // Self-addressed traffic is queued like any other packet.
  logic unused_self;
  assign unused_self = self_match;
  assign self_hit    = 1'b0;
`endif

  assign full   = (count == (AW+1)'(DEPTH));
  assign inj    = (count != '0);
  assign inject = mem[rp];

  // A full FIFO refuses the push even if the head pops in the same cycle.
  assign wr   = pkt_push && !full && !self_hit;
  assign drop = pkt_push && (full || self_hit);
  assign pop  = inj && inj_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem      <= '0;
      rp       <= '0;
      wp       <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= pkt_in;
        wp      <= wp + 1'b1;
      end
      if (pop)
        rp <= rp + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_inject_fifo.sv
module tb_inject_fifo;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  X, Y;
  logic [15:0] pkt_in;
  logic        pkt_push;
  logic        full;
  logic [15:0] inject;
  logic        inj;
  logic        inj_ack;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  int npass = 0;
  int ntot  = 0;

  inject_fifo #(.LL(16), .MM(2), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset), .X(X), .Y(Y),
    .pkt_in(pkt_in), .pkt_push(pkt_push), .full(full),
    .inject(inject), .inj(inj), .inj_ack(inj_ack),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] p, input logic ack);
    pkt_in = p; pkt_push = 1'b1; inj_ack = ack;
    step();
    pkt_push = 1'b0; inj_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    X = 2'd2; Y = 2'd1;
    pkt_in = '0; pkt_push = 1'b0; inj_ack = 1'b0;
    reset = 1'b1;
    #12;
    chk("rst_inj", inj, 0);
    chk("rst_count", count, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_full", full, 0);
    reset = 1'b0;
    step();

    // ack while empty is ignored
    inj_ack = 1'b1; step(); inj_ack = 1'b0;
    chk("ack_empty_count", count, 0);

    // basic ordering
    push(16'h1A01, 0);
    chk("wr_lat_inj", inj, 1);
    chk("wr_lat_head", inject, 16'h1A01);
    push(16'h2B02, 0);
    push(16'h3C03, 0);
    chk("three_count", count, 3);
    step();
    chk("head_stable", inject, 16'h1A01);
    inj_ack = 1'b1;
    step(); chk("pop1_head", inject, 16'h2B02);
    step(); chk("pop2_head", inject, 16'h3C03);
    step(); chk("pop3_inj", inj, 0); chk("pop3_count", count, 0);
    inj_ack = 1'b0;

    // overflow
    push(16'h1111, 0); push(16'h2222, 0); push(16'h3333, 0); push(16'h4444, 0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    push(16'hFFFF, 0);
    chk("ovf_drop", drop_cnt, 1);
    chk("ovf_count", count, 4);
    chk("ovf_head", inject, 16'h1111);
    push(16'h5555, 1);
    chk("full_pushack_drop", drop_cnt, 2);
    chk("full_pushack_count", count, 3);
    chk("full_pushack_head", inject, 16'h2222);

    // asynchronous reset mid-queue: outputs clear before the next edge
    #2 reset = 1'b1;
    #1;
    chk("async_rst_inj", inj, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_drop", drop_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step();

    // sustained push+ack across pointer wrap
    for (int i = 0; i < 10; i++) begin
      push(16'h0100 + 16'(i), 1);
      chk($sformatf("stream_head%0d", i), inject, 16'h0100 + 32'(i));
      chk($sformatf("stream_count%0d", i), count, 1);
    end
    inj_ack = 1'b1; step(); inj_ack = 1'b0;
    chk("stream_drain", inj, 0);

    // drop counter saturation
    push(16'h1111, 0); push(16'h2222, 0); push(16'h3333, 0); push(16'h4444, 0);
    for (int i = 0; i < 254; i++) push(16'hFFFF, 0);
    chk("drop_254", drop_cnt, 8'hFE);
    for (int i = 0; i < 46; i++) push(16'hFFFF, 0);
    chk("drop_sat", drop_cnt, 8'hFF);
    chk("drop_sat_count", count, 4);
    chk("drop_sat_head", inject, 16'h1111);

    // self-addressed packet (dest 2,1)
    do_reset();
    push(16'h9123, 0);
`ifdef INJ_SELF_DROP_EN
    chk("self_count", count, 0);
    chk("self_drop", drop_cnt, 1);
`else
    chk("self_count", count, 1);
    chk("self_head", inject, 16'h9123);
    chk("self_drop", drop_cnt, 0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/inject_fifo.md
# inject_fifo

Injection-side buffer between a node's packet generator and the router's local inject port. Accepts packets from the generator with a push strobe, queues them in a small FIFO, and presents the head packet to the router with a valid/acknowledge handshake. Decouples generator rate from router arbitration and counts packets lost to overflow.

## Interface

**Parameters**
- `LL`, 16: packet width in bits.
- `MM`, 2: coordinate width; equals log2(LL)/2.
- `DEPTH`, 4: FIFO entries; must be a power of two and at least 2.
- `AW`, 2: pointer width; equals log2(DEPTH).

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `X` in MM: this node's X coordinate, static after reset.
- `Y` in MM: this node's Y coordinate, static after reset.
- `pkt_in` in LL: packet from the generator. Bits [LL-1:LL-MM] hold dest X; bits [LL-MM-1:LL-2MM] hold dest Y; the rest is payload.
- `pkt_push` in 1: generator write strobe, one packet per cycle high.
- `full` out 1: FIFO holds DEPTH entries.
- `inject` out LL: head-of-queue packet to the router.
- `inj` out 1: head valid; high exactly when the FIFO is not empty.
- `inj_ack` in 1: router accepted the head this cycle; meaningful only when `inj`=1.
- `count` out AW+1: current occupancy, 0..DEPTH.
- `drop_cnt` out 8: saturating count of discarded packets.

## Operation

- Storage: DEPTH×LL register array, read pointer `rp` and write pointer `wp` (AW bits, wrap modulo DEPTH), occupancy `count`.
- Write: when `pkt_push`=1 and `full`=0, store `pkt_in` at `wp` and increment `wp`.
- Overflow: when `pkt_push`=1 and `full`=1, discard the packet, increment `drop_cnt`, and leave the FIFO unchanged.
- Full blocks a write even if a pop happens in the same cycle. No write-through when full.
- Read: `inject` is `mem[rp]`, combinational from registered state. When `inj`=1 and `inj_ack`=1, increment `rp`.
- `inj_ack` while empty is ignored.
- Simultaneous accepted write and pop: `count` stays the same and both pointers advance.
- `count` goes up by 1 on a write alone, down by 1 on a pop alone, and never leaves 0..DEPTH.
- `full` = (`count`==DEPTH). `inj` = (`count`!=0).
- `drop_cnt` saturates at 8'hFF and does not wrap.
- The router must hold its view of `inject` stable until it acks. The FIFO guarantees that `inject` changes only after a pop or when an empty FIFO receives a write.

## Timing

- Reset values: `full`=0, `inj`=0, `count`=0, `drop_cnt`=0, `rp`=`wp`=0. `inject` equals mem[0]; its contents are don't-care while `inj`=0, but the array resets to 0.
- Reset asserted mid-operation discards all queued packets asynchronously. No ack is honored during reset.
- Write latency: a packet pushed at edge N into an empty FIFO gives `inj`=1 and `inject`=packet after edge N.
- Pop latency: an ack sampled at edge N presents the next entry (or `inj`=0) after edge N.
- Sustained throughput is one packet per cycle when push and ack are both high every cycle and the FIFO is non-empty and non-full.
- Pointer wrap: after entry DEPTH-1 the pointer returns to 0 with no bubble.

## Configuration

- `INJ_SELF_DROP_EN` defined: a push whose dest X/Y equals (`X`,`Y`) is not stored. It increments `drop_cnt`, as overflow does, whether or not the FIFO is full. This prevents self-addressed traffic from consuming router bandwidth.
- Undefined: self-addressed packets are queued and injected like any other packet.

## Test plan

- Reset then idle: `inj`=0, `count`=0, `drop_cnt`=0. Assert `reset` mid-queue with `count`=3: all three outputs return to 0 immediately, before the next edge.
- Push 16'h1A01, 16'h2B02, 16'h3C03 on consecutive cycles with no ack: `count`=3. `inject`=16'h1A01 stays stable. Then ack three cycles: outputs 1A01, 2B02, 3C03 in order, then `inj`=0.
- Fill to 4 with no ack, then push 16'hFFFF: `full`=1, `drop_cnt`=1, head unchanged. Push and ack in the same cycle while full: push dropped (`drop_cnt`=2), `count`=3.
- Continuous push plus ack for 10 cycles from empty: `count` holds at 1 after the first edge, and packets emerge in order across pointer wrap.
- Push 300 packets while full: `drop_cnt` saturates at 8'hFF.
- With `INJ_SELF_DROP_EN` defined, `X`=2, `Y`=1, push 16'h9xxx (dest 2,1): `count` stays 0 and `drop_cnt`=1. Without the macro, `count`=1.
